stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_pkg.sv | 7 +
 rtl/stream_rr_arbiter_pick.sv | 21 ++
 rtl/stream_rr_arbiter.sv | 93 +++++++++
 tb/tb_stream_rr_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// stream_rr_arbiter_pkg: shared FSM state type and default sizing for stream_rr_arbiter
package stream_rr_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN = 4;
endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// rr_priority_pick: first set request scanning ptr, ptr+1, ... modulo NUM_REQ
module rr_priority_pick import stream_rr_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    any = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin burst arbiter merging NUM_REQ streams; STREAM_RR_ARBITER_ID_EN adds o_id
module stream_rr_arbiter import stream_rr_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_valid,
  output logic [NUM_REQ-1:0]            i_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_data
`ifdef STREAM_RR_ARBITER_ID_EN
  ,
  output logic [$clog2(NUM_REQ)-1:0]    o_id
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  state_t state, state_n;
  logic [IW-1:0] g, g_n, ptr, ptr_n, pick, g_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic any, xfer, last, drop;
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign lane[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(i_valid),
    .ptr(ptr),
    .idx(pick),
    .any(any)
  );
  assign g_inc = (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
  assign xfer = (state == GRANT) && i_valid[g] && i_ready[g];
  assign drop = (state == GRANT) && !i_valid[g];
  assign last = xfer && (cnt == CW'(BURST_LEN - 1));
  always_comb begin
    i_ready = '0;
    if (state == GRANT) i_ready[g] = !o_valid || o_ready;
  end
  always_comb begin
    state_n = state;
    g_n = g;
    ptr_n = ptr;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (any) begin
        state_n = GRANT;
        g_n = pick;
        cnt_n = '0;
      end
    end else if (drop || last) begin
      state_n = IDLE;
      ptr_n = g_inc;
    end else if (xfer) begin
      cnt_n = cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  // Output register: a held beat survives until accepted, reset drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data <= lane[g];
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end
`ifdef STREAM_RR_ARBITER_ID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_id <= '0;
    else if (xfer) o_id <= g;
  end
`endif
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: randomized scoreboard bench against a transaction-level round-robin model
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] i_valid = '0;
  logic [N-1:0] i_ready;
  logic [N*DW-1:0] i_data = '0;
  logic o_valid;
  logic o_ready = 1'b0;
  logic [DW-1:0] o_data;
`ifdef STREAM_RR_ARBITER_ID_EN
  logic [IW-1:0] o_id;
`endif
  int vectors = 0;
  int miscompares = 0;
  bit m_busy, m_ov;
  int m_g, m_ptr, m_cnt;
  logic [IW+DW-1:0] sb[$];
  logic [IW+DW-1:0] exp_b;
  always #5 clk = ~clk;
  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk),
    .reset(reset),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_data(i_data),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data(o_data)
`ifdef STREAM_RR_ARBITER_ID_EN
    ,
    .o_id(o_id)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0;
    m_ov = 0;
    m_g = 0;
    m_ptr = 0;
    m_cnt = 0;
    sb.delete();
  endtask
  // One clock edge of the arbitration rules, at beat/grant granularity
  task automatic model_edge(input logic [N-1:0] rdy);
    bit xfer;
    xfer = m_busy && i_valid[m_g] && rdy[m_g];
    if (xfer) sb.push_back({IW'(m_g), i_data[m_g*DW +: DW]});
    m_ov = xfer || (m_ov && !o_ready);
    if (!m_busy) begin
      for (int s = 0; s < N && !m_busy; s++)
        if (i_valid[(m_ptr + s) % N]) begin
          m_busy = 1;
          m_g = (m_ptr + s) % N;
          m_cnt = 0;
        end
    end else begin
      if (xfer) m_cnt++;
      if (!i_valid[m_g] || m_cnt == BL) begin
        m_busy = 0;
        m_ptr = (m_g + 1) % N;
      end
    end
  endtask
  task automatic step(input logic [N-1:0] mask, input int vp, input int rp);
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      i_valid[k] = mask[k] && (int'($urandom_range(99)) < vp);
      i_data[k*DW +: DW] = DW'($urandom);
    end
    o_ready = int'($urandom_range(99)) < rp;
    #1;
    exp_rdy = '0;
    if (m_busy && (!m_ov || o_ready)) exp_rdy[m_g] = 1'b1;
    check("i_ready", 32'(i_ready), 32'(exp_rdy));
    check("o_valid", 32'(o_valid), 32'(m_ov));
    @(posedge clk);
    model_edge(exp_rdy);
  endtask
  task automatic pulse_reset();
    int n = 0;
    while (!m_ov && n < 50) begin
      step('1, 100, 0);
      n++;
    end
    @(negedge clk);
    i_valid = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_i_ready", 32'(i_ready), 0);
    check("rst_o_data", 32'(o_data), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat: got unexpected data %0h, expected no beat at %0t", o_data, $time);
      end else begin
        exp_b = sb.pop_front();
        check("o_data", 32'(o_data), 32'(exp_b[DW-1:0]));
`ifdef STREAM_RR_ARBITER_ID_EN
        check("o_id", 32'(o_id), 32'(exp_b[IW+DW-1:DW]));
`endif
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_o_valid", 32'(o_valid), 0);
    check("reset_i_ready", 32'(i_ready), 0);
    check("reset_o_data", 32'(o_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step(4'b0010, 100, 100);
    repeat (40) step(4'b1111, 100, 100);
    repeat (60) step(4'b1111, 100, 30);
    repeat (20) step(4'b1001, 100, 100);
    repeat (30) step(4'b0100, 60, 100);
    pulse_reset();
    repeat (20) step(4'b1111, 100, 100);
    repeat (1500) step(4'b1111, 75, 70);
    pulse_reset();
    repeat (500) step(4'b1111, 90, 50);
    repeat (10) step('0, 0, 100);
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
